// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter.
// master = the side that feeds operands and consumes results.
// slave  = the shifter itself.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 10,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   amt;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;

  modport master (
    output in_valid, A, amt, mode, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, A, amt, mode, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit.
// Stage k shifts by 2^k when amt[k] is set.
// The result leaves as {carry, data}.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
// Optional macro BSHIFT_ROTATE_EN enables the rotate datapath.
// Without it, mode 11 behaves exactly like SLL.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 10,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  pipelined_barrel_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // One shift step by a fixed distance n.
  // The value is widened by one bit so that the last bit shifted out
  // lands in a fixed position.
  function automatic logic [WIDTH:0] stageShift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int               n
  );
    logic [WIDTH:0] extL;
    logic [WIDTH:0] extR;
    logic [WIDTH:0] extA;
    logic [WIDTH:0] res;
`ifdef BSHIFT_ROTATE_EN
    logic [WIDTH-1:0] rot;
`endif
    extL = {1'b0, d} << n;
    extR = {d, 1'b0} >> n;
    extA = $signed({d, 1'b0}) >>> n;
    res  = extL;
`ifdef BSHIFT_ROTATE_EN
    rot  = (d << (n % WIDTH)) | (d >> (WIDTH - (n % WIDTH)));
`endif
    case (m)
      MODE_SRL: res = {extR[0], extR[WIDTH:1]};
      MODE_SRA: res = {extA[0], extA[WIDTH:1]};
`ifdef BSHIFT_ROTATE_EN
      MODE_ROL: res = {rot[0], rot};
`endif
      default:  res = extL;
    endcase
    return res;
  endfunction

  logic [SHW-1:0]   stValid;
  logic [WIDTH-1:0] stData  [SHW];
  logic [SHW-1:0]   stCarry;
  logic [SHW-1:0]   stAmt   [SHW];
  logic [1:0]       stMode  [SHW];

  logic [SHW:0]     stReady;

  logic [SHW-1:0]   nxtValid;
  logic [WIDTH-1:0] nxtData [SHW];
  logic [SHW-1:0]   nxtCarry;
  logic [SHW-1:0]   nxtAmt  [SHW];
  logic [1:0]       nxtMode [SHW];

  // A stage may load when it is empty or when some stage between it and
  // the output is empty (or the output is being taken).
  // Written without a self-referencing chain, so in_ready never depends on in_valid.
  always_comb begin
    stReady = '0;
    for (int k = 0; k <= SHW; k++) begin
      stReady[k] = bus.out_ready;
      for (int j = k; j < SHW; j++) begin
        if (!stValid[j]) stReady[k] = 1'b1;
      end
    end
  end

  // Next value for every stage.
  // The stage input is either the bus (stage 0) or the previous register.
  // That input is shifted when its amt bit for this stage is set.
  always_comb begin
    logic [WIDTH:0] sh;
    nxtValid = '0;
    nxtCarry = '0;
    for (int k = 0; k < SHW; k++) begin
      nxtData[k] = '0;
      nxtAmt[k]  = '0;
      nxtMode[k] = '0;
    end

    nxtValid[0] = bus.in_valid;
    nxtAmt[0]   = bus.amt;
    nxtMode[0]  = bus.mode;
    sh = stageShift(bus.A, bus.mode, 1);
    if (bus.amt[0]) begin
      nxtData[0]  = sh[WIDTH-1:0];
      nxtCarry[0] = sh[WIDTH];
    end else begin
      nxtData[0]  = bus.A;
      nxtCarry[0] = 1'b0;
    end

    for (int k = 1; k < SHW; k++) begin
      nxtValid[k] = stValid[k-1];
      nxtAmt[k]   = stAmt[k-1];
      nxtMode[k]  = stMode[k-1];
      sh = stageShift(stData[k-1], stMode[k-1], 1 << k);
      if (stAmt[k-1][k]) begin
        nxtData[k]  = sh[WIDTH-1:0];
        nxtCarry[k] = sh[WIDTH];
      end else begin
        nxtData[k]  = stData[k-1];
        nxtCarry[k] = stCarry[k-1];
      end
    end
  end

  // Stage registers.
  // Reset clears all of them.
  // Otherwise each stage loads only while its ready is high, which holds
  // stalled data in place and squeezes out bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stValid <= '0;
      stCarry <= '0;
      for (int k = 0; k < SHW; k++) begin
        stData[k] <= '0;
        stAmt[k]  <= '0;
        stMode[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (stReady[k]) begin
          stValid[k] <= nxtValid[k];
          stData[k]  <= nxtData[k];
          stCarry[k] <= nxtCarry[k];
          stAmt[k]   <= nxtAmt[k];
          stMode[k]  <= nxtMode[k];
        end
      end
    end
  end

  assign bus.in_ready  = stReady[0];
  assign bus.out_valid = stValid[SHW-1];
  assign bus.out       = {stCarry[SHW-1], stData[SHW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Testbench for pipelined_barrel_shifter at WIDTH=10.
// Expected values for mode 11 follow BSHIFT_ROTATE_EN.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 10;
  localparam int SHW   = 4;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   amt;
    logic [1:0]       mode;
    logic [WIDTH:0]   exp;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vecs [16];

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic setVec(input int idx, input string name, input logic [WIDTH-1:0] a,
                        input logic [SHW-1:0] amt, input logic [1:0] mode,
                        input logic [WIDTH:0] exp);
    vecs[idx].name = name;
    vecs[idx].a    = a;
    vecs[idx].amt  = amt;
    vecs[idx].mode = mode;
    vecs[idx].exp  = exp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Send one operand into an idle pipeline.
  // Count negedges until out_valid shows, then check the latency and the value.
  task automatic applyStimulus(input int idx);
    int lat;
    @(negedge clk);
    bus.A        = vecs[idx].a;
    bus.amt      = vecs[idx].amt;
    bus.mode     = vecs[idx].mode;
    bus.in_valid = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    checkOutput({vecs[idx].name, " latency"}, lat, SHW);
    checkOutput(vecs[idx].name, bus.out, vecs[idx].exp);
  endtask

  initial begin
    int sent;
    int recv;
    logic stalled;
    logic [WIDTH:0] prevOut;

    errors = 0;
    checks = 0;

    setVec(0,  "sll4",  10'b0000001101, 4'd4,  2'b00, 11'b0_0011010000);
    setVec(1,  "srl1",  10'b0000001101, 4'd1,  2'b01, 11'b1_0000000110);
    setVec(2,  "sra3",  10'b1000000000, 4'd3,  2'b10, 11'b0_1111000000);
`ifdef BSHIFT_ROTATE_EN
    setVec(3,  "rol1",  10'b1000000001, 4'd1,  2'b11, 11'b1_0000000011);
`else
    setVec(3,  "rol1",  10'b1000000001, 4'd1,  2'b11, 11'b1_0000000010);
`endif
    setVec(4,  "sll10", 10'b0000000001, 4'd10, 2'b00, 11'b1_0000000000);
    setVec(5,  "sra15", 10'b1000000000, 4'd15, 2'b10, 11'b1_1111111111);
    setVec(6,  "sll0",  10'b1010101010, 4'd0,  2'b00, 11'b0_1010101010);
    setVec(7,  "srl10", 10'b1000000000, 4'd10, 2'b01, 11'b1_0000000000);
    setVec(8,  "srl11", 10'b1111111111, 4'd11, 2'b01, 11'b0_0000000000);
    setVec(9,  "sll11", 10'b1111111111, 4'd11, 2'b00, 11'b0_0000000000);
    setVec(10, "sra2",  10'b0101010101, 4'd2,  2'b10, 11'b0_0001010101);
    setVec(11, "sra10", 10'b0111111111, 4'd10, 2'b10, 11'b0_0000000000);
`ifdef BSHIFT_ROTATE_EN
    setVec(12, "rol10", 10'b1100000001, 4'd10, 2'b11, 11'b1_1100000001);
    setVec(13, "rol13", 10'b0000000111, 4'd13, 2'b11, 11'b0_0000111000);
`else
    setVec(12, "rol10", 10'b1100000001, 4'd10, 2'b11, 11'b1_0000000000);
    setVec(13, "rol13", 10'b0000000111, 4'd13, 2'b11, 11'b0_0000000000);
`endif
    setVec(14, "sll9",  10'b0000000011, 4'd9,  2'b00, 11'b1_1000000000);
    setVec(15, "srl5",  10'b1011010000, 4'd5,  2'b01, 11'b1_0000010110);

    // Reset state
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.amt       = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset out", bus.out, '0);
    checkOutput("reset in_ready", bus.in_ready, 1'b1);
    rst = 1'b1;

    // Directed table, one operand at a time
    for (int i = 0; i < 16; i++) applyStimulus(i);
    repeat (2) @(negedge clk);

    // Back-to-back stream of 8 with a 3-cycle output stall
    sent    = 0;
    recv    = 0;
    stalled = 1'b0;
    prevOut = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checkOutput("stall valid held", bus.out_valid, 1'b1);
        checkOutput("stall out held", bus.out, prevOut);
      end
      bus.out_ready = !(cyc >= 5 && cyc < 8);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.A    = vecs[sent].a;
        bus.amt  = vecs[sent].amt;
        bus.mode = vecs[sent].mode;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checkOutput({"stream ", vecs[recv].name}, bus.out, vecs[recv].exp);
        recv++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prevOut = bus.out;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("stream count", recv, 8);
    repeat (2) @(negedge clk);
    checkOutput("stream no extra", bus.out_valid, 1'b0);

    // Reset in the middle of a stream
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      bus.A        = vecs[cyc + 8].a;
      bus.amt      = vecs[cyc + 8].amt;
      bus.mode     = vecs[cyc + 8].mode;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("pre-reset out_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid reset out_valid", bus.out_valid, 1'b0);
    checkOutput("mid reset out", bus.out, '0);
    checkOutput("mid reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4);
    @(negedge clk);
    checkOutput("post-reset drained", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
